// File: rtl/fp_add_pkg.sv
// Shared types, constants and binary32 field helpers for the sequenced FP adder.
package fp_add_pkg;

    // Controller states, one per datapath step.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CMP   = 3'd1,
        S_ALIGN = 3'd2,
        S_ADD   = 3'd3,
        S_NORM  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam logic [7:0]  EXP_MAX = 8'd255;
    localparam logic [7:0]  BIAS    = 8'd127;
    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [31:0] POS_INF = 32'h7F80_0000;

    function automatic logic f_sign(input logic [31:0] x);
        return x[31];
    endfunction

    function automatic logic [7:0] f_exp(input logic [31:0] x);
        return x[30:23];
    endfunction

    function automatic logic [22:0] f_frac(input logic [31:0] x);
        return x[22:0];
    endfunction

endpackage

// File: rtl/fp_add_sequencer_exp_compare.sv
// Combinational exponent subtractor: magnitude of the difference plus borrow.
module fp_exp_compare #(
    parameter int W = 8
) (
    input  logic [W-1:0] exp_a,
    input  logic [W-1:0] exp_b,
    output logic [W-1:0] diff,
    output logic         a_lt_b
);

    logic [W:0] d_ab;

    // The borrow of a - b tells which exponent is larger; diff is always |a - b|.
    always_comb begin
        d_ab   = {1'b0, exp_a} - {1'b0, exp_b};
        a_lt_b = d_ab[W];
        diff   = a_lt_b ? (exp_b - exp_a) : d_ab[W-1:0];
    end

endmodule

// File: rtl/fp_add_sequencer.sv
// Multi-cycle binary32 adder controller: compare, align, add, normalise, pack.
// Handshakes: a transfer happens on a rising edge where valid and ready are both
// high; out_valid holds with result stable until out_ready is seen.
module fp_add_sequencer
    import fp_add_pkg::*;
#(
    parameter int EXP_W     = 8,
    parameter int MAN_W     = 23,
    parameter int ALIGN_CAP = 25
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        busy
);

    localparam int CNT_W = $clog2(ALIGN_CAP + 1);

    state_t             state;
    logic [31:0]        op_a;
    logic [31:0]        op_b;
    logic [EXP_W-1:0]   exp_r;
    logic [MAN_W:0]     man_big;
    logic [MAN_W:0]     man_small;
    logic               sign_big;
    logic               sign_small;
    logic               resolved;
    logic [CNT_W-1:0]   cnt;

    // Operand classification on the captured pair (denormals count as zero).
    logic               sa, sb;
    logic [EXP_W-1:0]   ea, eb;
    logic [MAN_W-1:0]   fa, fb;
    logic               a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

    assign sa     = f_sign(op_a);
    assign sb     = f_sign(op_b);
    assign ea     = f_exp(op_a);
    assign eb     = f_exp(op_b);
    assign fa     = f_frac(op_a);
    assign fb     = f_frac(op_b);
    assign a_zero = (ea == '0);
    assign b_zero = (eb == '0);
    assign a_inf  = (ea == EXP_MAX) && (fa == '0);
    assign b_inf  = (eb == EXP_MAX) && (fb == '0);
    assign a_nan  = (ea == EXP_MAX) && (fa != '0);
    assign b_nan  = (eb == EXP_MAX) && (fb != '0);

    logic [EXP_W-1:0]   diff;
    logic               a_lt_b;
    logic [CNT_W-1:0]   k;

    fp_exp_compare #(.W(EXP_W)) u_exp_compare (
        .exp_a  (ea),
        .exp_b  (eb),
        .diff   (diff),
        .a_lt_b (a_lt_b)
    );

    assign k = (diff > EXP_W'(ALIGN_CAP)) ? CNT_W'(ALIGN_CAP) : diff[CNT_W-1:0];

    logic               is_special;
    logic [31:0]        special_res;

    // Resolve NaN / infinity / zero operands without touching the datapath.
    always_comb begin
        is_special  = a_nan | b_nan | a_inf | b_inf | a_zero | b_zero;
        special_res = '0;
        if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) begin
            special_res = QNAN;
        end else if (a_inf) begin
            special_res = op_a;
        end else if (b_inf) begin
            special_res = op_b;
        end else if (a_zero && b_zero) begin
            special_res = '0;
        end else if (a_zero) begin
            special_res = op_b;
        end else if (b_zero) begin
            special_res = op_a;
        end
    end

    logic               mag_ge;
    logic [MAN_W+1:0]   raw_sum;
    logic               add_sign;
    logic [EXP_W-1:0]   exp_inc;
    logic [EXP_W-1:0]   norm_exp;
    logic [MAN_W:0]     norm_man;

    // Magnitude add/subtract of the aligned mantissas and the one-step normalise shift.
    always_comb begin
        mag_ge = (man_big >= man_small);
        if (sign_big == sign_small) begin
            raw_sum  = {1'b0, man_big} + {1'b0, man_small};
            add_sign = sign_big;
        end else if (mag_ge) begin
            raw_sum  = {1'b0, man_big} - {1'b0, man_small};
            add_sign = sign_big;
        end else begin
            raw_sum  = {1'b0, man_small} - {1'b0, man_big};
            add_sign = sign_small;
        end
        exp_inc  = exp_r + EXP_W'(1);
        norm_exp = exp_r - EXP_W'(1);
        norm_man = man_big << 1;
    end

    // Controller FSM with registered handshake outputs and result.
    // Specials resolved in CMP pass through the ADD slot untouched so their
    // latency matches a zero-shift operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            op_a       <= '0;
            op_b       <= '0;
            exp_r      <= '0;
            man_big    <= '0;
            man_small  <= '0;
            sign_big   <= 1'b0;
            sign_small <= 1'b0;
            resolved   <= 1'b0;
            cnt        <= '0;
            result     <= '0;
            in_ready   <= 1'b0;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        op_a     <= a;
                        op_b     <= b;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= S_CMP;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                S_CMP: begin
                    if (is_special) begin
                        result   <= special_res;
                        resolved <= 1'b1;
                        state    <= S_ADD;
                    end else begin
                        resolved <= 1'b0;
                        cnt      <= k;
                        if (a_lt_b) begin
                            exp_r      <= eb;
                            man_big    <= {1'b1, fb};
                            man_small  <= {1'b1, fa};
                            sign_big   <= sb;
                            sign_small <= sa;
                        end else begin
                            exp_r      <= ea;
                            man_big    <= {1'b1, fa};
                            man_small  <= {1'b1, fb};
                            sign_big   <= sa;
                            sign_small <= sb;
                        end
                        state <= (k != '0) ? S_ALIGN : S_ADD;
                    end
                end
                S_ALIGN: begin
                    man_small <= man_small >> 1;
                    cnt       <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state <= S_ADD;
                    end
                end
                S_ADD: begin
                    if (resolved) begin
                        out_valid <= 1'b1;
                        state     <= S_DONE;
                    end else if (raw_sum[MAN_W+1]) begin
                        if (exp_inc == EXP_MAX) begin
                            result <= {add_sign, POS_INF[30:0]};
                        end else begin
                            result <= {add_sign, exp_inc, raw_sum[MAN_W:1]};
                        end
                        out_valid <= 1'b1;
                        state     <= S_DONE;
                    end else if (raw_sum == '0) begin
                        result    <= '0;
                        out_valid <= 1'b1;
                        state     <= S_DONE;
                    end else if (raw_sum[MAN_W]) begin
                        result    <= {add_sign, exp_r, raw_sum[MAN_W-1:0]};
                        out_valid <= 1'b1;
                        state     <= S_DONE;
                    end else begin
                        man_big  <= raw_sum[MAN_W:0];
                        sign_big <= add_sign;
                        state    <= S_NORM;
                    end
                end
                S_NORM: begin
                    if (norm_exp == '0) begin
                        result    <= {sign_big, 31'd0};
                        out_valid <= 1'b1;
                        state     <= S_DONE;
                    end else if (norm_man[MAN_W]) begin
                        result    <= {sign_big, norm_exp, norm_man[MAN_W-1:0]};
                        out_valid <= 1'b1;
                        state     <= S_DONE;
                    end else begin
                        man_big <= norm_man;
                        exp_r   <= norm_exp;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
